shift_left_iterative: RTL and testbench
=======================================

SHIFT_LEFT_ITERATIVE -- requirements
Module: shift_left_iterative

Interface
REQ-001 Parameter WIDTH, default 16, data width in bits.
REQ-002 Parameter CNT_W, default 4, shift-amount width; the maximum shift is 2^CNT_W-1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; sampled only while ready=1.
REQ-006 In  input  WIDTH  operand, captured on the edge that accepts start.
REQ-007 Cnt  input  CNT_W  shift amount, captured with In.
REQ-008 Mode  input  1  0=logical shift left, 1=rotate left; captured with In.
REQ-009 ready  output  1  high only in IDLE.
REQ-010 Out  output  WIDTH  result register; holds its value between completions.
REQ-011 valid  output  1  one-cycle pulse marking a new Out.

Function
REQ-012 The design SHALL be a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1: the FSM SHALL capture In, Cnt and Mode, then enter SHIFT if Cnt!=0, else DONE.
REQ-014 SHIFT: each cycle SHALL shift the working register left by exactly 1 bit.
  - Mode=0: LSB filled with 0.
  - Mode=1 (macro on): LSB filled with the prior MSB.
  - Remaining count decrements by 1.
REQ-015 SHIFT SHALL move to DONE on the edge performing the final shift (remaining count==1).
REQ-016 DONE SHALL drive Out from the working register, assert valid for exactly one cycle, then return to IDLE unconditionally.
REQ-017 Latency SHALL be exactly Cnt+1 rising edges from the accepting edge to the first cycle with valid=1; Cnt=0 gives 1.
REQ-018 start while ready=0 (SHIFT or DONE) SHALL be ignored, with no effect on the in-flight operation.
REQ-019 Out SHALL change only on entry to DONE; all bits shifted past the MSB are discarded in logical mode.
REQ-020 Back-to-back: start may be accepted in the IDLE cycle immediately following DONE.
REQ-021 Throughput SHALL be one operation per Cnt+2 cycles maximum.

Reset
REQ-022 rst_n low SHALL asynchronously force IDLE, Out=0, valid=0, ready=1, and clear the working register and count.
REQ-023 Reset asserted mid-SHIFT or in DONE SHALL abort the operation with no valid pulse; the first start after release behaves as from power-up.

Configuration
REQ-024 Macro SHL_ROTATE_EN defined: Mode=1 SHALL select rotate-left per REQ-014.
REQ-025 Macro SHL_ROTATE_EN undefined: the Mode port SHALL remain present but be ignored; all operations are logical shift left.

Structure
REQ-026 A shared shifter package/include SHALL hold:
  - the FSM state encodings (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10);
  - the default WIDTH/CNT_W constants.
REQ-027 The single-bit stage SHALL be a sub-module, shift_left_stage1: a WIDTH-wide row of 2:1 muxes with fill-bit input, instantiated once in the datapath.

Verification
REQ-028 In=0x0001, Cnt=4, Mode=0 -> valid on 5th edge after accept, Out=0x0010, ready low for the 5 intervening cycles.
REQ-029 In=0x8001, Cnt=1: Mode=0 -> Out=0x0002; with SHL_ROTATE_EN and Mode=1 -> Out=0x0003; without macro, Mode=1 -> Out=0x0002.
REQ-030 In=0xABCD, Cnt=0 -> valid on 1st edge, Out=0xABCD; In=0xFFFF, Cnt=15 -> valid on 16th edge, Out=0x8000.
REQ-031 Accept In=0x0003, Cnt=2; pulse start with In=0x1111, Cnt=1 during SHIFT -> single valid, Out=0x000C, second request dropped.
REQ-032 Assert rst_n low 2 cycles into In=0x00F0, Cnt=8 -> immediately Out=0, valid=0, ready=1; no valid pulse follows; next op In=0x0001, Cnt=3 -> Out=0x0008.

Source files
------------

// File: rtl/shift_left_iterative_pkg.sv
// Shared definitions for the iterative left shifter.
// Holds the FSM state encoding and the default data/count widths used by the
// interface and the top module.
package shift_left_iterative_pkg;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned DefaultCntW  = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_left_iterative_if.sv
// Request/response bundle for the iterative left shifter.
// master: start, In (operand), Cnt (shift amount), Mode (0=shift, 1=rotate)
//         driven towards the shifter; ready, Out, valid received back.
// slave : the shifter side of the same signals.
interface shift_left_iterative_if
    import shift_left_iterative_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CNT_W = DefaultCntW
) ();

    logic             start;
    logic [WIDTH-1:0] In;
    logic [CNT_W-1:0] Cnt;
    logic             Mode;
    logic             ready;
    logic [WIDTH-1:0] Out;
    logic             valid;

    modport master (
        output start, In, Cnt, Mode,
        input  ready, Out, valid
    );

    modport slave (
        input  start, In, Cnt, Mode,
        output ready, Out, valid
    );

endinterface

// File: rtl/shift_left_stage1.sv
// One-bit left-shift stage: a WIDTH-wide row of 2:1 muxes.
// Ports: din (data in), fill (bit entering at the LSB), shift_en (select
// shifted data), dout (result).
module shift_left_stage1 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] din,
    input  logic             fill,
    input  logic             shift_en,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = din;
        if (shift_en) begin
            dout = {din[WIDTH-2:0], fill};
        end
    end

endmodule

// File: rtl/shift_left_iterative.sv
// Iterative left shifter / rotator, one bit per clock.
// Ports: clk, rst_n (async active-low), bus (slave modport: start/In/Cnt/Mode
// request, ready/Out/valid response).
// A request is captured in IDLE, shifted Cnt times in SHIFT, and the result is
// published from DONE: Out loads on entry to DONE, valid pulses for one cycle
// on the edge leaving DONE.
// Build option: define SHL_ROTATE_EN to make Mode=1 select rotate-left;
// otherwise Mode is ignored and every operation is a logical shift.
module shift_left_iterative
    import shift_left_iterative_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CNT_W = DefaultCntW
) (
    input logic                  clk,
    input logic                  rst_n,
    shift_left_iterative_if.slave bus
);

`ifdef SHL_ROTATE_EN
    localparam bit RotateEn = 1'b1;
`else
    localparam bit RotateEn = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;

    logic             shift_en;
    logic             fill;
    logic [WIDTH-1:0] stage_out;

    // With rotation compiled out the fill bit folds to a constant zero.
    assign fill = RotateEn & mode_q & work_q[WIDTH-1];

    shift_left_stage1 #(
        .WIDTH(WIDTH)
    ) u_stage (
        .din     (work_q),
        .fill    (fill),
        .shift_en(shift_en),
        .dout    (stage_out)
    );

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        out_d    = out_q;
        valid_d  = 1'b0;
        shift_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    work_d = bus.In;
                    cnt_d  = bus.Cnt;
                    mode_d = bus.Mode;
                    if (bus.Cnt != '0) begin
                        state_d = StShift;
                    end else begin
                        state_d = StDone;
                        out_d   = bus.In;
                    end
                end
            end
            StShift: begin
                shift_en = 1'b1;
                work_d   = stage_out;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StDone;
                    out_d   = stage_out;
                end
            end
            StDone: begin
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            work_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign bus.ready = (state_q == StIdle);
    assign bus.Out   = out_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_shift_left_iterative.sv
// Self-checking bench for shift_left_iterative (default WIDTH=16, CNT_W=4).
// Honours SHL_ROTATE_EN the same way the design does.
module tb_shift_left_iterative;

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;

`ifdef SHL_ROTATE_EN
    localparam bit Rot = 1'b1;
`else
    localparam bit Rot = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    shift_left_iterative_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    shift_left_iterative #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result of shifting a left by c places, or rotating when m and Rot.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input int c, input bit m);
        logic [2*W-1:0] w;
        w = {{W{1'b0}}, a} << c;
        if (Rot && m) return w[W-1:0] | w[2*W-1:W];
        return w[W-1:0];
    endfunction

    // Issue one request (caller is 1ns after an edge with ready=1) and follow it
    // until valid. lat = edges from the accepting edge to the valid cycle
    // (-1 on timeout); ready_low counts cycles in between with ready=0.
    // Returns in the valid cycle, 1ns after its edge.
    task automatic drive_op(input logic [W-1:0] a, input logic [CW-1:0] c, input logic m,
                            input bit inject, output logic [W-1:0] res, output int lat,
                            output int ready_low);
        int e;
        bus.start = 1'b1;
        bus.In    = a;
        bus.Cnt   = c;
        bus.Mode  = m;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.In    = W'($urandom);
        bus.Cnt   = CW'($urandom);
        bus.Mode  = 1'($urandom);
        res       = 'x;
        lat       = -1;
        ready_low = 0;
        for (e = 0; e <= 40; e++) begin
            if (bus.valid) begin
                res = bus.Out;
                lat = e;
                break;
            end
            if (!bus.ready) ready_low++;
            if (inject && e == 1) begin
                bus.start = 1'b1;
                bus.In    = 16'h1111;
                bus.Cnt   = 4'd1;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.In    = '0;
        bus.Cnt   = '0;
        bus.Mode  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b want=1", bus.ready);
        end
        total++;
        if (bus.valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%b want=0", bus.valid);
        end
        total++;
        if (bus.Out !== 16'h0000) begin
            bad++;
            $display("FAIL reset_out got=%h want=0000", bus.Out);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [W-1:0] res;
        int           lat;
        int           rl;
        logic [W-1:0] want;

        drive_op(16'h0001, 4'd4, 1'b0, 1'b0, res, lat, rl);
        total++;
        if (res !== 16'h0010 || lat != 5 || rl != 5) begin
            bad++;
            $display("FAIL shl4 out=%h lat=%0d rdy_low=%0d want out=0010 lat=5 rdy_low=5",
                     res, lat, rl);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.valid !== 1'b0 || bus.Out !== 16'h0010) begin
            bad++;
            $display("FAIL valid_pulse valid=%b out=%h want valid=0 out=0010", bus.valid, bus.Out);
        end

        drive_op(16'h8001, 4'd1, 1'b0, 1'b0, res, lat, rl);
        total++;
        if (res !== 16'h0002 || lat != 2) begin
            bad++;
            $display("FAIL shl1 out=%h lat=%0d want out=0002 lat=2", res, lat);
        end

        want = Rot ? 16'h0003 : 16'h0002;
        drive_op(16'h8001, 4'd1, 1'b1, 1'b0, res, lat, rl);
        total++;
        if (res !== want || lat != 2) begin
            bad++;
            $display("FAIL rot1 out=%h lat=%0d want out=%h lat=2", res, lat, want);
        end

        drive_op(16'hABCD, 4'd0, 1'b0, 1'b0, res, lat, rl);
        total++;
        if (res !== 16'hABCD || lat != 1 || rl != 1) begin
            bad++;
            $display("FAIL cnt0 out=%h lat=%0d rdy_low=%0d want out=abcd lat=1 rdy_low=1",
                     res, lat, rl);
        end

        drive_op(16'hFFFF, 4'd15, 1'b0, 1'b0, res, lat, rl);
        total++;
        if (res !== 16'h8000 || lat != 16) begin
            bad++;
            $display("FAIL cnt15 out=%h lat=%0d want out=8000 lat=16", res, lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ignore_busy();
        logic [W-1:0] res;
        int           lat;
        int           rl;
        int           extra;
        drive_op(16'h0003, 4'd2, 1'b0, 1'b1, res, lat, rl);
        total++;
        if (res !== 16'h000C || lat != 3) begin
            bad++;
            $display("FAIL busy_start out=%h lat=%0d want out=000c lat=3", res, lat);
        end
        extra = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.valid || !bus.ready) extra++;
        end
        total++;
        if (extra != 0 || bus.Out !== 16'h000C) begin
            bad++;
            $display("FAIL busy_dropped activity=%0d out=%h want activity=0 out=000c",
                     extra, bus.Out);
        end
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] res;
        int           lat;
        int           rl;
        int           pulses;
        bus.start = 1'b1;
        bus.In    = 16'h00F0;
        bus.Cnt   = 4'd8;
        bus.Mode  = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.Out !== 16'h0000 || bus.valid !== 1'b0 || bus.ready !== 1'b1) begin
            bad++;
            $display("FAIL async_reset out=%h valid=%b ready=%b want out=0000 valid=0 ready=1",
                     bus.Out, bus.valid, bus.ready);
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.valid) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL abort_no_valid pulses=%0d want 0", pulses);
        end
        drive_op(16'h0001, 4'd3, 1'b0, 1'b0, res, lat, rl);
        total++;
        if (res !== 16'h0008 || lat != 4) begin
            bad++;
            $display("FAIL after_reset out=%h lat=%0d want out=0008 lat=4", res, lat);
        end
        @(posedge clk);
        #1;
    endtask

    // Each op starts in the valid cycle of the previous one.
    task automatic test_back_to_back_random();
        logic [W-1:0] a;
        logic [CW-1:0] c;
        logic          m;
        logic [W-1:0] res;
        logic [W-1:0] want;
        int            lat;
        int            rl;
        for (int i = 0; i < 40; i++) begin
            a    = W'($urandom);
            c    = CW'($urandom_range(0, 15));
            m    = 1'($urandom);
            want = model(a, int'(c), m);
            drive_op(a, c, m, (i % 5) == 2, res, lat, rl);
            total++;
            if (res !== want || lat != int'(c) + 1 || rl != int'(c) + 1) begin
                bad++;
                $display("FAIL rand_%0d in=%h cnt=%0d mode=%b out=%h lat=%0d want out=%h lat=%0d",
                         i, a, c, m, res, lat, want, int'(c) + 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_ignore_busy();
        test_reset_abort();
        test_back_to_back_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
